// File: rtl/cpu_pkg.sv
// Shared encodings for the Simple RISC Machine controller: states, opcodes,
// ALU operations, register/write-back selects and the control word.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_WAIT   = 3'd0,
    ST_DECODE = 3'd1,
    ST_GET_A  = 3'd2,
    ST_GET_B  = 3'd3,
    ST_EXEC   = 3'd4,
    ST_WR_REG = 3'd5,
    ST_WR_IMM = 3'd6
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_RM   = 3'b001;
  localparam logic [2:0] SEL_RD   = 3'b010;
  localparam logic [2:0] SEL_RN   = 3'b100;

  localparam logic [1:0] VSEL_C   = 2'b00;
  localparam logic [1:0] VSEL_IMM = 2'b10;

  typedef struct packed {
    logic       w;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic       write;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // Where DECODE goes for each instruction; unknown encodings fall back to WAIT.
  function automatic state_t decode_target(input logic [2:0] opcode,
                                           input logic [1:0] op);
    state_t target;
    target = ST_WAIT;
    if (opcode == OPC_MOV) begin
      if (op == OP_MOV_IMM)      target = ST_WR_IMM;
      else if (op == OP_MOV_REG) target = ST_GET_B;
    end else if (opcode == OPC_ALU) begin
      if (op == OP_MVN) target = ST_GET_B;
      else              target = ST_GET_A;
    end
    return target;
  endfunction

  function automatic logic is_cmp(input logic [2:0] opcode,
                                  input logic [1:0] op);
    return (opcode == OPC_ALU) && (op == OP_CMP);
  endfunction

endpackage

// File: rtl/cpu_ctrl_next.sv
// Combinational next-state logic for the cpu_ctrl sequencer.
module cpu_ctrl_next
  import cpu_pkg::*;
(
  input  state_t     state,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output state_t     next_state
);

  always_comb begin
    next_state = ST_WAIT;
    case (state)
      ST_WAIT:   next_state = s ? ST_DECODE : ST_WAIT;
      ST_DECODE: next_state = decode_target(opcode, op);
      ST_GET_A:  next_state = ST_GET_B;
      ST_GET_B:  next_state = ST_EXEC;
      // CMP only updates status, so it has nothing to write back
      ST_EXEC:   next_state = is_cmp(opcode, op) ? ST_WAIT : ST_WR_REG;
      ST_WR_REG: next_state = ST_WAIT;
      ST_WR_IMM: next_state = ST_WAIT;
      default:   next_state = ST_WAIT;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle control FSM for the Simple RISC Machine datapath: state
// register plus Moore output decode (opcode/op only matter in EXEC).
module cpu_ctrl
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       write,
  output logic [1:0] ALUop
);

  state_t state;
  state_t next_state;
  ctrl_t  ctrl;

  cpu_ctrl_next u_next (
    .state      (state),
    .s          (s),
    .opcode     (opcode),
    .op         (op),
    .next_state (next_state)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_WAIT;
    else       state <= next_state;
  end

  always_comb begin
    ctrl = CTRL_IDLE;
    case (state)
      ST_WAIT: ctrl.w = 1'b1;
      ST_GET_A: begin
        ctrl.nsel  = SEL_RN;
        ctrl.loada = 1'b1;
      end
      ST_GET_B: begin
        ctrl.nsel  = SEL_RM;
        ctrl.loadb = 1'b1;
      end
      ST_EXEC: begin
        // MOV Rd,Rm is computed as 0 + Rm with the A input forced to zero
        if (opcode == OPC_MOV) begin
          ctrl.asel   = 1'b1;
          ctrl.alu_op = ALU_ADD;
          ctrl.loadc  = 1'b1;
        end else if (is_cmp(opcode, op)) begin
          ctrl.alu_op = ALU_SUB;
          ctrl.loads  = 1'b1;
        end else begin
          ctrl.loadc = 1'b1;
          case (op)
            OP_ADD:  ctrl.alu_op = ALU_ADD;
            OP_AND:  ctrl.alu_op = ALU_AND;
            OP_MVN:  ctrl.alu_op = ALU_NOTB;
            default: ctrl.alu_op = ALU_SUB;
          endcase
        end
      end
      ST_WR_REG: begin
        ctrl.nsel  = SEL_RD;
        ctrl.vsel  = VSEL_C;
        ctrl.write = 1'b1;
      end
      ST_WR_IMM: begin
        ctrl.nsel  = SEL_RN;
        ctrl.vsel  = VSEL_IMM;
        ctrl.write = 1'b1;
      end
      default: ctrl = CTRL_IDLE;
    endcase
  end

  assign w     = ctrl.w;
  assign nsel  = ctrl.nsel;
  assign vsel  = ctrl.vsel;
  assign loada = ctrl.loada;
  assign loadb = ctrl.loadb;
  assign loadc = ctrl.loadc;
  assign loads = ctrl.loads;
  assign asel  = ctrl.asel;
  assign bsel  = ctrl.bsel;
  assign write = ctrl.write;
  assign ALUop = ctrl.alu_op;

  // Enable groups are mutually exclusive by construction
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(write && loadc));
      assert ($onehot0(nsel));
    end
  end

endmodule
